watch_core_gen: RTL and testbench



---
 rtl/watch_core_gen.sv | 225 ++++++++++++++++++++++
 tb/tb_watch_core_gen.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_core_gen.sv
// Timekeeping core: 1 Hz prescaler, HH:MM:SS clock, time/alarm setting,
// daily alarm and free-running MM:SS stopwatch, with BCD display output.
module watch_core_gen #(
  parameter int CLK_FRE    = 27_000_000,
  parameter bit HOUR_12    = 1'b0,
  parameter int ALARM_SECS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic       key_dec,
  output logic [3:0] disp_d3,
  output logic [3:0] disp_d2,
  output logic [3:0] disp_d1,
  output logic [3:0] disp_d0,
  output logic [3:0] blink_mask,
  output logic [2:0] mode,
  output logic       second_led,
  output logic       pm,
  output logic       alarm_en,
  output logic       alarm_out
);

  localparam int PW = (CLK_FRE > 1) ? $clog2(CLK_FRE) : 1;
  localparam int AW = $clog2(ALARM_SECS + 1);
  localparam logic [PW-1:0] PRE_TOP  = PW'(CLK_FRE - 1);
  localparam logic [PW-1:0] PRE_HALF = PW'(CLK_FRE / 2);

  typedef enum logic [2:0] {
    NORMAL    = 3'd0,
    SET_MIN   = 3'd1,
    SET_HOUR  = 3'd2,
    SET_AMIN  = 3'd3,
    SET_AHOUR = 3'd4,
    STOPWATCH = 3'd5
  } mode_t;

  mode_t state, state_n;

  logic [PW-1:0] pre, sw_pre;
  logic [6:0] t_sec, t_min, t_hour;
  logic [6:0] al_min, al_hour;
  logic [6:0] sw_sec, sw_min;
  logic [6:0] n_sec, n_min, n_hour;
  logic [AW-1:0] al_cnt;
  logic sw_run;

  function automatic logic [6:0] step(
    input logic [6:0] v,
    input logic [6:0] top,
    input logic       up
  );
    if (up) return (v == top) ? 7'd0 : v + 7'd1;
    return (v == 7'd0) ? top : v - 7'd1;
  endfunction

  // Only the highest-priority pulse of a cycle is acted on
  logic k_mode, k_inc, k_dec, k_any, edit;
  assign k_mode = key_mode;
  assign k_inc  = key_inc & ~key_mode;
  assign k_dec  = key_dec & ~key_mode & ~key_inc;
  assign k_any  = key_mode | key_inc | key_dec;
  assign edit   = k_inc | k_dec;

  logic tick, sw_tick, set_t, fire;
  assign tick    = (pre == PRE_TOP);
  assign sw_tick = sw_run && (sw_pre == PRE_TOP);
  assign set_t   = (state == SET_MIN) || (state == SET_HOUR);

  assign second_led = (pre >= PRE_HALF);

  assign n_sec  = (t_sec == 7'd59) ? 7'd0 : t_sec + 7'd1;
  assign n_min  = (t_sec != 7'd59) ? t_min :
                  (t_min == 7'd59) ? 7'd0 : t_min + 7'd1;
  assign n_hour = (t_sec != 7'd59 || t_min != 7'd59) ? t_hour :
                  (t_hour == 7'd23) ? 7'd0 : t_hour + 7'd1;

  assign fire = tick && !set_t && alarm_en && (t_sec == 7'd59)
             && (n_min == al_min) && (n_hour == al_hour);

  always_ff @(posedge clk) begin
    if (rst) state <= NORMAL;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      NORMAL:    if (k_mode) state_n = SET_MIN;
      SET_MIN:   if (k_mode) state_n = SET_HOUR;
      SET_HOUR:  if (k_mode) state_n = SET_AMIN;
      SET_AMIN:  if (k_mode) state_n = SET_AHOUR;
      SET_AHOUR: if (k_mode) state_n = STOPWATCH;
      STOPWATCH: if (k_mode) state_n = NORMAL;
      default:   state_n = NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pre <= '0;
    else     pre <= tick ? '0 : pre + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_sec  <= '0;
      t_min  <= '0;
      t_hour <= '0;
    end else if (set_t) begin
      if (edit) begin
        t_sec <= '0;
        if (state == SET_MIN) t_min  <= step(t_min, 7'd59, k_inc);
        else                  t_hour <= step(t_hour, 7'd23, k_inc);
      end
    end else if (tick) begin
      t_sec  <= n_sec;
      t_min  <= n_min;
      t_hour <= n_hour;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      al_min   <= '0;
      al_hour  <= '0;
      alarm_en <= 1'b0;
      al_cnt   <= '0;
    end else begin
      if (edit && state == SET_AMIN)
        al_min <= step(al_min, 7'd59, k_inc);
      if (edit && state == SET_AHOUR)
        al_hour <= step(al_hour, 7'd23, k_inc);
      if (k_inc && state == NORMAL)
        alarm_en <= ~alarm_en;
      if (k_any)
        al_cnt <= '0;
      else if (fire)
        al_cnt <= AW'(ALARM_SECS);
      else if (tick && al_cnt != '0)
        al_cnt <= al_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (k_dec && state == STOPWATCH)) begin
      sw_pre <= '0;
      sw_sec <= '0;
      sw_min <= '0;
      sw_run <= 1'b0;
    end else begin
      if (k_inc && state == STOPWATCH) sw_run <= ~sw_run;
      if (sw_run) sw_pre <= sw_tick ? '0 : sw_pre + 1'b1;
      if (sw_tick) begin
        if (sw_sec == 7'd59) begin
          sw_sec <= '0;
          sw_min <= (sw_min == 7'd99) ? 7'd0 : sw_min + 7'd1;
        end else begin
          sw_sec <= sw_sec + 7'd1;
        end
      end
    end
  end

  logic [6:0] hi, lo, hh;
  logic       hr, pm_n;
  logic [3:0] blink_n;

  always_comb begin
    hi = t_hour;
    lo = t_min;
    hr = 1'b1;
    unique case (state)
      SET_AMIN, SET_AHOUR: begin
        hi = al_hour;
        lo = al_min;
      end
      STOPWATCH: begin
        hi = sw_min;
        lo = sw_sec;
        hr = 1'b0;
      end
      default: ;
    endcase
    hh   = hi;
    pm_n = 1'b0;
    if (HOUR_12 && hr) begin
      pm_n = (hi >= 7'd12);
      if (hi == 7'd0)       hh = 7'd12;
      else if (hi > 7'd12)  hh = hi - 7'd12;
    end
  end

  always_comb begin
    blink_n = 4'b0000;
    unique case (state)
      SET_MIN, SET_AMIN:   blink_n = 4'b0011;
      SET_HOUR, SET_AHOUR: blink_n = 4'b1100;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_d3    <= '0;
      disp_d2    <= '0;
      disp_d1    <= '0;
      disp_d0    <= '0;
      blink_mask <= '0;
      mode       <= '0;
      pm         <= 1'b0;
      alarm_out  <= 1'b0;
    end else begin
      disp_d3    <= 4'(hh / 7'd10);
      disp_d2    <= 4'(hh % 7'd10);
      disp_d1    <= 4'(lo / 7'd10);
      disp_d0    <= 4'(lo % 7'd10);
      blink_mask <= blink_n;
      mode       <= state;
      pm         <= pm_n;
      alarm_out  <= (al_cnt != '0);
    end
  end

endmodule

// File: tb/tb_watch_core_gen.sv
// Bench for watch_core_gen: seconds-of-day reference model, directed
// scenarios and random key traffic on a 24 h and a 12 h instance.
module tb_watch_core_gen;

  localparam int CF = 4;
  localparam int AS = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_mode = 1'b0;
  logic key_inc  = 1'b0;
  logic key_dec  = 1'b0;

  logic [3:0] a_d3, a_d2, a_d1, a_d0, a_blink;
  logic [2:0] a_mode;
  logic a_led, a_pm, a_aen, a_alarm;
  logic [3:0] b_d3, b_d2, b_d1, b_d0, b_blink;
  logic [2:0] b_mode;
  logic b_led, b_pm, b_aen, b_alarm;

  watch_core_gen #(.CLK_FRE(CF), .HOUR_12(1'b0), .ALARM_SECS(AS)) dut (
    .clk(clk), .rst(rst),
    .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec),
    .disp_d3(a_d3), .disp_d2(a_d2), .disp_d1(a_d1), .disp_d0(a_d0),
    .blink_mask(a_blink), .mode(a_mode), .second_led(a_led),
    .pm(a_pm), .alarm_en(a_aen), .alarm_out(a_alarm)
  );

  watch_core_gen #(.CLK_FRE(CF), .HOUR_12(1'b1), .ALARM_SECS(AS)) dut12 (
    .clk(clk), .rst(rst),
    .key_mode(key_mode), .key_inc(key_inc), .key_dec(key_dec),
    .disp_d3(b_d3), .disp_d2(b_d2), .disp_d1(b_d1), .disp_d0(b_d0),
    .blink_mask(b_blink), .mode(b_mode), .second_led(b_led),
    .pm(b_pm), .alarm_en(b_aen), .alarm_out(b_alarm)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Reference state: time of day in seconds, stopwatch in seconds
  int m_pre, m_tod, m_alh, m_alm, m_rem, m_mode, m_swpre, m_sw;
  bit m_aen, m_run;
  logic [24:0] exp_a, exp_b;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [24:0] view(input bit h12);
    int hi, lo;
    bit hr, p;
    logic [3:0] bl;
    hi = m_tod / 3600;
    lo = (m_tod / 60) % 60;
    hr = 1'b1;
    p  = 1'b0;
    if (m_mode == 3 || m_mode == 4) begin
      hi = m_alh;
      lo = m_alm;
    end else if (m_mode == 5) begin
      hi = m_sw / 60;
      lo = m_sw % 60;
      hr = 1'b0;
    end
    if (h12 && hr) begin
      p  = (hi >= 12);
      hi = (hi % 12 == 0) ? 12 : hi % 12;
    end
    bl = (m_mode == 1 || m_mode == 3) ? 4'b0011 :
         (m_mode == 2 || m_mode == 4) ? 4'b1100 : 4'b0000;
    return {4'(hi / 10), 4'(hi % 10), 4'(lo / 10), 4'(lo % 10),
            bl, 3'(m_mode), p, (m_rem > 0)};
  endfunction

  task automatic model_step();
    bit tk, swtk, fire;
    int d, hh, mm;
    if (rst) begin
      m_pre = 0; m_tod = 0; m_alh = 0; m_alm = 0; m_rem = 0;
      m_mode = 0; m_swpre = 0; m_sw = 0; m_aen = 0; m_run = 0;
      exp_a = '0;
      exp_b = '0;
      return;
    end
    exp_a = view(1'b0);
    exp_b = view(1'b1);
    tk = (m_pre == CF - 1);
    m_pre = (m_pre + 1) % CF;
    fire = 1'b0;
    if (tk && m_mode != 1 && m_mode != 2) begin
      m_tod = (m_tod + 1) % 86400;
      fire = m_aen && (m_tod == m_alh * 3600 + m_alm * 60);
    end
    if (tk && m_rem > 0) m_rem--;
    if (fire) m_rem = AS;
    if (key_mode || key_inc || key_dec) m_rem = 0;
    swtk = m_run && (m_swpre == CF - 1);
    if (m_run) m_swpre = (m_swpre + 1) % CF;
    if (swtk) m_sw = (m_sw + 1) % 6000;
    hh = m_tod / 3600;
    mm = (m_tod / 60) % 60;
    if (key_mode) begin
      m_mode = (m_mode + 1) % 6;
    end else if (key_inc || key_dec) begin
      d = key_inc ? 1 : -1;
      case (m_mode)
        0: if (key_inc) m_aen = !m_aen;
        1: m_tod = hh * 3600 + ((mm + d + 60) % 60) * 60;
        2: m_tod = ((hh + d + 24) % 24) * 3600 + mm * 60;
        3: m_alm = (m_alm + d + 60) % 60;
        4: m_alh = (m_alh + d + 24) % 24;
        default: begin
          if (key_inc) m_run = !m_run;
          else begin
            m_sw = 0;
            m_swpre = 0;
            m_run = 0;
          end
        end
      endcase
    end
  endtask

  task automatic cyc(input bit km, input bit ki, input bit kd);
    key_mode = km;
    key_inc  = ki;
    key_dec  = kd;
    @(posedge clk);
    model_step();
    #1;
    check("out", {a_d3, a_d2, a_d1, a_d0, a_blink, a_mode, a_pm, a_alarm},
          exp_a);
    check("out12", {b_d3, b_d2, b_d1, b_d0, b_blink, b_mode, b_pm, b_alarm},
          exp_b);
    check("led", {a_led, b_led}, {2{m_pre >= CF / 2}});
    check("aen", {a_aen, b_aen}, {2{m_aen}});
    @(negedge clk);
    key_mode = 1'b0;
    key_inc  = 1'b0;
    key_dec  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  task automatic press_mode(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0);
  endtask

  function automatic logic [15:0] adisp();
    return {a_d3, a_d2, a_d1, a_d0};
  endfunction

  initial begin
    logic [7:0] pat;
    logic [15:0] prev;
    int n;

    @(negedge clk);
    rst = 1'b1;
    idle(2);
    check("rst_disp", adisp(), 16'h0000);
    check("rst_misc", {a_blink, a_mode, a_pm, a_alarm, a_aen, a_led}, 0);
    rst = 1'b0;
    cyc(0, 0, 0);
    check("rst12", {b_d3, b_d2, b_d1, b_d0, b_pm}, {16'h1200, 1'b0});
    check("rst24", adisp(), 16'h0000);

    pat = '0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0);
      pat = {pat[6:0], a_led};
    end
    check("led_pat", pat, 8'hCC);

    press_mode(1);
    cyc(0, 0, 1);
    idle(1);
    check("min59", {a_d1, a_d0, a_blink}, {8'h59, 4'b0011});
    cyc(0, 1, 0);
    idle(1);
    check("min00", {adisp(), a_blink}, {16'h0000, 4'b0011});
    cyc(0, 0, 1);
    idle(400);
    check("frozen", adisp(), 16'h0059);

    press_mode(1);
    cyc(0, 0, 1);
    idle(1);
    check("hr23", {a_d3, a_d2, a_blink}, {8'h23, 4'b1100});
    check("hr23_12", {b_d3, b_d2, b_pm}, {8'h11, 1'b1});
    cyc(0, 1, 0);
    idle(1);
    check("h12_0", {b_d3, b_d2, b_pm}, {8'h12, 1'b0});
    check("h24_0", {a_d3, a_d2, a_pm}, 9'h0);
    for (int i = 0; i < 12; i++) cyc(0, 1, 0);
    idle(1);
    check("h12_12", {b_d3, b_d2, b_pm}, {8'h12, 1'b1});
    cyc(0, 1, 0);
    idle(1);
    check("h12_13", {b_d3, b_d2, b_pm}, {8'h01, 1'b1});
    for (int i = 0; i < 10; i++) cyc(0, 1, 0);

    press_mode(1);
    cyc(0, 1, 0);
    press_mode(3);
    cyc(0, 1, 0);
    check("aen_on", a_aen, 1'b1);

    prev = adisp();
    n = 0;
    while (adisp() != 16'h0000 && n < 400) begin
      prev = adisp();
      cyc(0, 0, 0);
      n++;
    end
    check("roll_prev", prev, 16'h2359);
    check("roll_now", adisp(), 16'h0000);

    n = 0;
    while (!a_alarm && n < 400) begin
      cyc(0, 0, 0);
      n++;
    end
    check("al_rise", a_alarm, 1'b1);
    check("al_time", adisp(), 16'h0001);
    n = 0;
    while (a_alarm && n < 200) begin
      cyc(0, 0, 0);
      n++;
    end
    check("al_len", n, AS * CF);

    press_mode(3);
    cyc(0, 1, 0);
    press_mode(3);
    n = 0;
    while (!a_alarm && n < 400) begin
      cyc(0, 0, 0);
      n++;
    end
    check("al2_rise", {a_alarm, adisp()}, {1'b1, 16'h0002});
    idle(5 * CF);
    cyc(0, 0, 1);
    check("al_hold", a_alarm, 1'b1);
    idle(1);
    check("al_quiet", {a_alarm, a_aen}, 2'b01);

    press_mode(5);
    cyc(0, 1, 0);
    idle(301);
    check("sw115", adisp(), 16'h0115);
    press_mode(1);
    idle(36);
    press_mode(5);
    idle(1);
    check("sw125", {adisp(), a_mode}, {16'h0125, 3'd5});
    cyc(0, 0, 1);
    idle(1);
    check("sw_clr", adisp(), 16'h0000);
    idle(8);
    check("sw_stop", adisp(), 16'h0000);

    press_mode(1);
    cyc(1, 1, 0);
    idle(1);
    check("prio", {a_mode, a_aen}, {3'd1, 1'b1});

    press_mode(4);
    cyc(0, 1, 0);
    idle(20);
    rst = 1'b1;
    cyc(0, 1, 0);
    check("rst_run", {adisp(), a_blink, a_mode, a_pm, a_alarm, a_aen, a_led},
          0);
    rst = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 1999) == 0);
      cyc($urandom_range(0, 31) == 0,
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 15) == 0);
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
